// File: rtl/seq_mult_pkg.sv
// Shared types and default sizing for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int N_A_DEFAULT = 8;
  localparam int N_B_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_dp.sv
// Radix-2 shift-add datapath: one multiplier bit per step, LSB first.
// acc_nxt is the accumulator value after the current step, so the last step's product is visible before it is registered.
module seq_mult_dp #(
  parameter int N_A = 8,
  parameter int N_B = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [N_A-1:0]     a_mag,
  input  logic [N_B-1:0]     b_mag,
  output logic [N_A+N_B-1:0] acc_nxt
);

  localparam int N_OUT = N_A + N_B;

  logic [N_OUT-1:0] acc_q;
  logic [N_OUT-1:0] mcand_q;
  logic [N_B-1:0]   mplier_q;

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= {{N_B{1'b0}}, a_mag};
      mplier_q <= b_mag;
    end else if (step) begin
      acc_q    <= acc_nxt;
      mcand_q  <= {mcand_q[N_OUT-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[N_B-1:1]};
    end
  end

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential signed/unsigned multiplier: operands captured on accept, N_B shift-add cycles,
// product held in DONE until taken by the consumer.
module seq_mult_unit
  import seq_mult_pkg::*;
#(
  parameter int N_A = N_A_DEFAULT,
  parameter int N_B = N_B_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_A-1:0]     a,
  input  logic [N_B-1:0]     b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_A+N_B-1:0] result,
  output logic               busy
);

  localparam int N_OUT = N_A + N_B;
  localparam int CW    = $clog2(N_B + 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic [N_OUT-1:0] result_q;

  logic             accept;
  logic             last_step;
  logic [N_A-1:0]   a_mag_d;
  logic [N_B-1:0]   b_mag_d;
  logic             neg_d;
  logic [N_OUT-1:0] acc_nxt;
  logic [N_OUT-1:0] prod_d;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_step = (state_q == RUN) && (cnt_q == CW'(1));

  // Most-negative input maps to 2^(N-1), which still fits the unsigned N-bit magnitude.
  assign a_mag_d = (signed_mode && a[N_A-1]) ? (~a + N_A'(1)) : a;
  assign b_mag_d = (signed_mode && b[N_B-1]) ? (~b + N_B'(1)) : b;
  assign neg_d   = signed_mode && (a[N_A-1] ^ b[N_B-1]);
  assign prod_d  = neg_q ? (~acc_nxt + N_OUT'(1)) : acc_nxt;

  seq_mult_dp #(
    .N_A (N_A),
    .N_B (N_B)
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .step    (state_q == RUN),
    .a_mag   (a_mag_d),
    .b_mag   (b_mag_d),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            cnt_q   <= CW'(N_B);
            neg_q   <= neg_d;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (last_step) begin
            state_q  <= DONE;
            result_q <= prod_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign result    = result_q;

endmodule

// File: doc/seq_mult_unit.md
SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

Interface
REQ-001 Parameter N_A, default 8, width of operand a; SHALL be >= 2.
REQ-002 Parameter N_B, default 8, width of operand b and RUN-state cycle count; SHALL be >= 2.
REQ-003 Localparam N_OUT = N_A+N_B, result width; SHALL NOT be overridable.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand request valid.
REQ-007 in_ready  output  1  unit accepts operands.
REQ-008 a  input  N_A  multiplicand.
REQ-009 b  input  N_B  multiplier.
REQ-010 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 result  output  N_OUT  product.
REQ-014 busy  output  1  high in RUN.

Function
REQ-015 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE); busy SHALL equal (state==RUN).
REQ-017 Accept event = in_valid && in_ready at a rising edge; at that edge a, b, signed_mode SHALL be captured and state SHALL go IDLE->RUN.
REQ-018 Operands SHALL be sampled only at the accept edge; later changes on a/b/signed_mode SHALL NOT affect the result.
REQ-019 In signed mode, captured operands SHALL be converted to magnitudes (N_A/N_B bits unsigned) and product sign = sign(a) XOR sign(b).
REQ-020 RUN SHALL perform one radix-2 shift-add step per cycle, processing one multiplier bit LSB first, for exactly N_B cycles via a down-counter.
REQ-021 At the N_B-th RUN edge, result SHALL be loaded with the N_OUT-bit magnitude product, two's-complement negated when signed_mode and sign differ, and state SHALL go RUN->DONE.
REQ-022 out_valid SHALL first be high in the cycle following the edge N_B edges after the accept edge (latency N_B cycles).
REQ-023 In DONE, result SHALL hold stable until out_valid && out_ready; at that edge state SHALL go DONE->IDLE.
REQ-024 in_valid during RUN or DONE SHALL be ignored (not accepted, no side effect).
REQ-025 result SHALL retain the last product in IDLE and RUN until overwritten by the next completion.
REQ-026 Zero operand(s) SHALL still take N_B RUN cycles and yield result 0 (no early termination).
REQ-027 Signed extremes SHALL be exact: magnitude of most-negative value SHALL be representable (e.g. -128 -> 128 in 8 bits unsigned).
REQ-028 out_ready high in DONE at the first out_valid cycle SHALL complete transfer in that single cycle (back-to-back throughput N_B+2 cycles/op).

Reset
REQ-029 reset high at a rising edge SHALL force state=IDLE, result=0, counter=0, all captured operand registers=0, regardless of state.
REQ-030 After reset: in_ready=1, out_valid=0, busy=0; reset SHALL take priority over accept and out handshake in the same cycle.
REQ-031 reset mid-RUN SHALL abandon the operation; no out_valid SHALL follow for it.

Structure
REQ-032 Package seq_mult_pkg SHALL hold the FSM state type (IDLE/RUN/DONE) and the N_A/N_B default constants.
REQ-033 Shift-add accumulator/multiplicand/multiplier registers SHALL live in sub-module seq_mult_dp; FSM, counter, handshake and sign handling in seq_mult_unit.
REQ-034 No multiplier operator SHALL be used in synthesisable RTL.

Verification
REQ-035 Unsigned, a=8'hFF, b=8'hFF, out_ready=1 -> out_valid after 8 cycles, result=16'hFE01, in_ready back high next cycle.
REQ-036 Signed, a=-128 (8'h80), b=127 (8'h7F) -> result=16'hC080; a=8'h80, b=8'h80 -> result=16'h4000.
REQ-037 Unsigned a=8'h05, b=8'h00 -> busy for 8 cycles, result=16'h0000; in_valid toggled and a changed during RUN -> result unaffected, no second accept.
REQ-038 out_ready held low 5 cycles in DONE with a=3, b=7 -> out_valid and result=16'h0015 stable all 5 cycles, IDLE one edge after out_ready rises.
REQ-039 reset asserted in 4th RUN cycle -> next cycle in_ready=1, out_valid=0, result=0; next accepted op (a=2, b=3) -> result=16'h0006.
REQ-040 Random back-to-back signed/unsigned ops vs reference model, N_A=12, N_B=6 instance -> all results match, spacing exactly N_B+2 cycles with in_valid/out_ready tied high.
